// File: rtl/full_subtractor_pkg.sv
// Shared definitions for the full subtractor leaf and its serial wrapper.
package full_subtractor_pkg;

  // Default serial word length.
  localparam int unsigned FS_WIDTH_DEFAULT = 8;

  // One cell result, handy when both outputs are carried together.
  typedef struct packed {
    logic diff;
    logic bout;
  } fs_bit_t;

  // Bits needed for a counter that can hold 0..width.
  function automatic int unsigned fs_cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// Pure combinational single-bit full subtractor: a - b - bin.
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/full_subtractor.sv
// Full subtractor with a combinational output core and a bit-serial,
// LSB-first WIDTH-bit word subtractor sharing the same cell.
module full_subtractor
  import full_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = FS_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             bin,
  output logic             diff,
  output logic             bout,
  input  logic             en,
  input  logic             first,
  output logic [WIDTH-1:0] res_q,
  output logic             borrow_q,
  output logic             done
);

  localparam int unsigned CW = fs_cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  logic             brw_r;
  logic [WIDTH-1:0] sh;
  logic [CW-1:0]    cnt;

  logic             s_bin;
  logic             s_diff;
  logic             s_bout;
  logic [WIDTH-1:0] sh_next;
  logic [CW-1:0]    cnt_next;
  logic             word_end;

  // Output core: always live, independent of clock and reset.
  fs_cell u_core (
    .a    (a),
    .b    (b),
    .bin  (bin),
    .diff (diff),
    .bout (bout)
  );

  // Serial core: borrow comes from bin at a word start, else from the register.
  fs_cell u_serial (
    .a    (a),
    .b    (b),
    .bin  (s_bin),
    .diff (s_diff),
    .bout (s_bout)
  );

  // Borrow select, next shift value and word-completion detect.
  always_comb begin
    s_bin    = first ? bin : brw_r;
    sh_next  = {s_diff, sh[WIDTH-1:1]};
    cnt_next = first ? CW'(1) : cnt + CW'(1);
    word_end = (cnt_next == LAST);
  end

  // Serial state: consume one bit per enabled clock, publish on the last bit.
  // After completion cnt returns to 0 while brw_r keeps the final borrow, so a
  // following word without first chains the borrow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brw_r    <= 1'b0;
      sh       <= '0;
      cnt      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (en) begin
        brw_r <= s_bout;
        sh    <= sh_next;
        if (word_end) begin
          res_q    <= sh_next;
          borrow_q <= s_bout;
          done     <= 1'b1;
          cnt      <= '0;
        end else begin
          cnt <= cnt_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_full_subtractor.sv
// Scoreboard bench for full_subtractor: stimulus pushes expected words,
// a monitor pops and compares on every done pulse.
module tb_full_subtractor;

  logic       clk = 1'b0;
  logic       clk_run = 1'b0;
  logic       rst_n = 1'b0;
  logic       a = 1'b0;
  logic       b = 1'b0;
  logic       bin = 1'b0;
  logic       en = 1'b0;
  logic       first = 1'b0;
  logic       diff;
  logic       bout;
  logic [7:0] res_q;
  logic       borrow_q;
  logic       done;

  int n_checks = 0;
  int n_fail = 0;

  // {borrow, result} expected per completed word
  logic [8:0] exp_q [$];

  // Truth table indexed by {a,b,bin}: {diff,bout}
  logic [1:0] tt [0:7] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};

  full_subtractor #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .diff     (diff),
    .bout     (bout),
    .en       (en),
    .first    (first),
    .res_q    (res_q),
    .borrow_q (borrow_q),
    .done     (done)
  );

  initial forever #5 clk = clk_run ? ~clk : clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, act=running req=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: act=0x%0h req=0x%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial forever begin
    @(negedge clk);
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_done: act=0x%0h/%0b req=no word pending", res_q, borrow_q);
      end else begin
        check("serial_word", {borrow_q, res_q}, exp_q.pop_front());
      end
    end
  end

  // Drive nbits of a word LSB-first; optional first on bit 0 and an en gap
  // (with first held high, which must be ignored) before bit gap_at.
  task automatic send_word(input logic [7:0] aw, input logic [7:0] bw, input logic b0,
                           input logic use_first, input int gap_at, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < 3; g++) begin
          en = 1'b0; first = 1'b1; a = 1'b1; b = 1'b0;
          @(posedge clk); #1;
        end
      end
      a     = aw[i];
      b     = bw[i];
      bin   = b0;
      first = use_first && (i == 0);
      en    = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    en = 1'b0; first = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [2:0] v;
    // Combinational core with the clock stopped and reset held.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      a = v[2]; b = v[1]; bin = v[0];
      #10;
      check($sformatf("comb_%0d%0d%0d", v[2], v[1], v[0]), {7'b0, diff, bout}, {7'b0, tt[i]});
    end
    check("reset_res", {borrow_q, res_q}, 9'h000);
    check("reset_done", {8'b0, done}, 9'h000);

    clk_run = 1'b1;
    a = 1'b0; b = 1'b0; bin = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 5 - 3, then 3 - 5, then 0 - 0 - 1, back to back with en held high.
    exp_q.push_back({1'b0, 8'h02}); send_word(8'h05, 8'h03, 1'b0, 1'b1, -1, 8);
    exp_q.push_back({1'b1, 8'hFE}); send_word(8'h03, 8'h05, 1'b0, 1'b1, -1, 8);
    exp_q.push_back({1'b1, 8'hFF}); send_word(8'h00, 8'h00, 1'b1, 1'b1, -1, 8);
    idle(2);

    // Multi-word chain: 0x00-0x01 leaves a borrow that feeds 0x05-0x02.
    exp_q.push_back({1'b1, 8'hFF}); send_word(8'h00, 8'h01, 1'b0, 1'b1, -1, 8);
    exp_q.push_back({1'b0, 8'h02}); send_word(8'h05, 8'h02, 1'b1, 1'b0, -1, 8);
    idle(2);

    // En gap of 3 cycles mid-word: 0xA5 - 0x5A.
    exp_q.push_back({1'b0, 8'h4B}); send_word(8'hA5, 8'h5A, 1'b0, 1'b1, 3, 8);
    idle(2);

    // Abort after 4 bits, restart with 0x10 - 0x01.
    send_word(8'h33, 8'h11, 1'b0, 1'b1, -1, 4);
    exp_q.push_back({1'b0, 8'h0F}); send_word(8'h10, 8'h01, 1'b0, 1'b1, -1, 8);
    idle(2);
    check("hold_res", {borrow_q, res_q}, {1'b0, 8'h0F});

    // Partial word leaving a borrow set, then async reset between edges.
    send_word(8'h00, 8'hFF, 1'b0, 1'b1, -1, 3);
    en = 1'b0; first = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_res", {borrow_q, res_q}, 9'h000);
    check("async_reset_done", {8'b0, done}, 9'h000);
    a = 1'b0; b = 1'b1; bin = 1'b1;
    #1;
    check("comb_in_reset_011", {7'b0, diff, bout}, 9'h001);
    a = 1'b1; b = 1'b0; bin = 1'b0;
    #1;
    check("comb_in_reset_100", {7'b0, diff, bout}, 9'h002);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // No first after reset: counter and borrow must start from 0 (bin ignored).
    exp_q.push_back({1'b0, 8'h04}); send_word(8'h07, 8'h03, 1'b1, 1'b0, -1, 8);
    idle(3);

    check("pending_words", 9'(exp_q.size()), 9'h000);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
